// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing controller: button sync/debounce, IDLE/RUN/PAUSE/LAP FSM, tick prescaler.
// Optional lap/freeze feature is enabled by defining STOPWATCH_LAP_EN.

module stopwatch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic pulse
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], raw};
            level_d <= level;
            // Any cycle where the synchronised input agrees with the level restarts the count.
            if (sync[1] != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign pulse = level & ~level_d;
endmodule

module stopwatch_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TICK_DIV        = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start_stop,
    input  logic       btn_reset,
    input  logic       btn_lap,
    output logic       tick,
    output logic       clear,
    output logic       freeze,
    output logic       running,
    output logic [1:0] state
);
    localparam int unsigned PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t        st;
    state_t        nxt;
    logic [PW-1:0] presc;
    logic          ss_ev;
    logic          rst_ev;
    logic          lap_ev;

    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk(clk), .reset_n(reset_n), .raw(btn_start_stop), .pulse(ss_ev)
    );

    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk(clk), .reset_n(reset_n), .raw(btn_reset), .pulse(rst_ev)
    );

`ifdef STOPWATCH_LAP_EN
    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk(clk), .reset_n(reset_n), .raw(btn_lap), .pulse(lap_ev)
    );
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_ev     = 1'b0;
`endif

    always_comb begin
        nxt = st;
        if (rst_ev) begin
            nxt = IDLE;
        end else if (ss_ev) begin
            nxt = (st == RUN || st == LAP) ? PAUSE : RUN;
        end else if (lap_ev) begin
            if (st == RUN)      nxt = LAP;
            else if (st == LAP) nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st      <= IDLE;
            presc   <= '0;
            tick    <= 1'b0;
            clear   <= 1'b0;
            freeze  <= 1'b0;
            running <= 1'b0;
        end else begin
            st      <= nxt;
            clear   <= rst_ev;
            running <= (nxt == RUN || nxt == LAP);
`ifdef STOPWATCH_LAP_EN
            freeze  <= (nxt == LAP);
`else
            freeze  <= 1'b0;
`endif
            tick    <= 1'b0;
            // The prescaler still advances on the cycle that leaves RUN/LAP; only its tick is dropped.
            if (rst_ev) begin
                presc <= '0;
            end else if (st == RUN || st == LAP) begin
                if (presc == PW'(TICK_DIV - 1)) begin
                    presc <= '0;
                    tick  <= (nxt == RUN || nxt == LAP);
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    assign state = st;
endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench for stopwatch_controller: reference model queues expected outputs per cycle,
// a monitor pops and compares on each falling edge; directed timing checks use fixed constants.
module tb_stopwatch_controller;
    localparam int unsigned DC = 4;
    localparam int unsigned TD = 10;
`ifdef STOPWATCH_LAP_EN
    localparam int LAP_EN = 1;
`else
    localparam int LAP_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       b_ss = 1'b0;
    logic       b_rst = 1'b0;
    logic       b_lap = 1'b0;
    logic       tick;
    logic       clear;
    logic       freeze;
    logic       running;
    logic [1:0] state;

    always #500 clk = ~clk;

    stopwatch_controller #(.DEBOUNCE_CYCLES(DC), .TICK_DIV(TD)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_start_stop(b_ss), .btn_reset(b_rst), .btn_lap(b_lap),
        .tick(tick), .clear(clear), .freeze(freeze), .running(running), .state(state)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model. Button index 0 = start/stop, 1 = reset, 2 = lap.
    // States as integers: 0 idle, 1 run, 2 pause, 3 lap.
    bit         hist[3][$];
    bit         lvl[3];
    bit         pend[3];
    int         mst;
    int         mpresc;
    logic [5:0] expq[$];

    function automatic void model_reset();
        for (int unsigned b = 0; b < 3; b++) begin
            hist[b].delete();
            for (int unsigned j = 0; j < DC + 2; j++) hist[b].push_back(1'b0);
            lvl[b]  = 1'b0;
            pend[b] = 1'b0;
        end
        mst    = 0;
        mpresc = 0;
    endfunction

    always @(posedge clk) begin : model
        bit raw[3];
        bit flip;
        int nst;
        bit etick;
        bit act_now;
        bit act_next;
        if (!reset_n) begin
            model_reset();
            expq.push_back(6'b0);
        end else begin
            raw[0] = b_ss;
            raw[1] = b_rst;
            raw[2] = b_lap;
            nst = mst;
            if (pend[1]) nst = 0;
            else if (pend[0]) nst = (mst == 1 || mst == 3) ? 2 : 1;
            else if (pend[2] && LAP_EN == 1) begin
                if (mst == 1) nst = 3;
                else if (mst == 3) nst = 1;
            end
            act_now  = (mst == 1 || mst == 3);
            act_next = (nst == 1 || nst == 3);
            etick = 1'b0;
            if (pend[1]) mpresc = 0;
            else if (act_now) begin
                mpresc = (mpresc + 1) % TD;
                etick  = (mpresc == 0) && act_next;
            end
            expq.push_back({etick, pend[1], (nst == 3), act_next, 2'(nst)});
            mst = nst;
            // Indices 0..DC-1 hold the samples the synchroniser has delivered over the last DC cycles.
            for (int unsigned b = 0; b < 3; b++) begin
                hist[b].push_back(raw[b]);
                void'(hist[b].pop_front());
                flip = 1'b1;
                for (int unsigned j = 0; j < DC; j++)
                    if (hist[b][j] == lvl[b]) flip = 1'b0;
                pend[b] = flip && !lvl[b];
                if (flip) lvl[b] = ~lvl[b];
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [5:0] e;
        check("sb_depth", expq.size(), 1);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("outputs", int'({tick, clear, freeze, running, state}), int'(e));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b, input int hold);
        if (b == 0) b_ss = 1'b1; else if (b == 1) b_rst = 1'b1; else b_lap = 1'b1;
        cycles(hold);
        b_ss = 1'b0; b_rst = 1'b0; b_lap = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output int n);
        n = -1;
        for (int i = 0; i <= budget; i++) begin
            if (state == s) begin n = i; break; end
            @(negedge clk);
        end
    endtask

    task automatic count_ticks(input int len, output int cnt);
        cnt = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (tick) cnt++;
        end
    endtask

    task automatic first_tick(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (tick) begin n = i; break; end
        end
    endtask

    initial begin : stim
        int n;
        int cnt;
        cycles(3);
        reset_n = 1'b1;
        cycles(3);
        check("reset_state", int'(state), 0);

        // Start from IDLE: raw high 10 cycles, state flips 7 cycles after the raw edge.
        b_ss = 1'b1;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (state == 2'b01 && n < 0) n = i;
            if (i == 10) b_ss = 1'b0;
        end
        check("start_latency", n, 7);
        count_ticks(100, cnt);
        check("ticks_100", cnt, 10);

        // Bouncing start/stop never stabilises long enough to register.
        for (int unsigned r = 0; r < 10; r++) begin
            b_ss = 1'b1; cycles(3);
            b_ss = 1'b0; cycles(1);
        end
        cycles(8);
        check("bounce_state", int'(state), 1);

        // Pause with the prescaler at 6 when the event lands, hold, then resume.
        n = -1;
        for (int i = 0; i < 20; i++) begin
            if (mpresc == 0) begin n = i; break; end
            @(negedge clk);
        end
        check("align_timeout", int'(n < 0), 0);
        press(0, 6);
        wait_state(2'b10, 20, n);
        check("pause_reach", int'(n < 0), 0);
        count_ticks(50, cnt);
        check("pause_ticks", cnt, 0);
        check("pause_state", int'(state), 2);
        press(0, 6);
        wait_state(2'b01, 20, n);
        check("resume_reach", int'(n < 0), 0);
        first_tick(30, n);
        check("resume_tick", n, 3);
        cycles(5);

        // Reset and start/stop together from RUN: reset wins.
        b_ss = 1'b1; b_rst = 1'b1;
        cycles(6);
        b_ss = 1'b0; b_rst = 1'b0;
        n = -1;
        for (int i = 0; i < 20; i++) begin
            if (clear) begin n = i; break; end
            @(negedge clk);
        end
        check("clear_seen", int'(n < 0), 0);
        check("clear_tick", int'(tick), 0);
        check("clear_state", int'(state), 0);
        @(negedge clk);
        check("clear_pulse", int'(clear), 0);
        cycles(8);
        press(0, 6);
        wait_state(2'b01, 20, n);
        check("restart_reach", int'(n < 0), 0);
        first_tick(30, n);
        check("restart_tick", n, 10);
        cycles(8);

        // Lap in RUN, then lap again.
        press(2, 6);
        cycles(4);
        check("lap_state", int'(state), (LAP_EN == 1) ? 3 : 1);
        check("lap_freeze", int'(freeze), LAP_EN);
        count_ticks(20, cnt);
        check("lap_ticks", cnt, 2);
        press(2, 6);
        cycles(4);
        check("unlap_state", int'(state), 1);
        check("unlap_freeze", int'(freeze), 0);

        // Asynchronous reset mid-run takes effect without a clock edge.
        @(negedge clk);
        #100 reset_n = 1'b0;
        #1 check("async_reset", int'({tick, clear, freeze, running, state}), 0);
        cycles(3);
        reset_n = 1'b1;
        cycles(10);
        check("post_reset_idle", int'(state), 0);

        // Random button activity, checked by the scoreboard.
        for (int unsigned r = 0; r < 300; r++) begin
            b_ss  = ($urandom_range(0, 3) == 0);
            b_rst = ($urandom_range(0, 15) == 0);
            b_lap = ($urandom_range(0, 3) == 0);
            cycles($urandom_range(1, 9));
        end
        b_ss = 1'b0; b_rst = 1'b0; b_lap = 1'b0;
        cycles(12);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
